// File: rtl/hilo_muldiv_ctrl_pkg.sv
// HI/LO mul/div controller shared definitions: op encodings and FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package hilo_muldiv_ctrl_pkg;

  // Same encoding the ALU decoder places on op_i.
  typedef enum logic [2:0] {
    HILO_NONE  = 3'd0,
    HILO_MULT  = 3'd1,
    HILO_MULTU = 3'd2,
    HILO_DIV   = 3'd3,
    HILO_DIVU  = 3'd4,
    HILO_MTHI  = 3'd5,
    HILO_MTLO  = 3'd6
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } hilo_state_e;

  // Signed variants take magnitudes up front and fix the sign at commit.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == HILO_MULT) || (op == HILO_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO controller bundle.
// Latency: n/a (wiring only).
// Backpressure: stall_o from the controller holds the EX stage.
// Ports: valid_i/op_i/src_a_i/src_b_i/flush_i driven by the pipeline (master);
//        stall_o/done_o/hi_o/lo_o driven by the controller (slave).
interface hilo_muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              valid_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] src_a_i;
  logic [DATA_W-1:0] src_b_i;
  logic              flush_i;
  logic              stall_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output valid_i, op_i, src_a_i, src_b_i, flush_i,
    input  stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, op_i, src_a_i, src_b_i, flush_i,
    output stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_ctrl_div_radix2.sv
// One restoring-division step: shift in the next dividend bit, trial subtract.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_i/quo_i current partial remainder and dividend/quotient shift
//        register, divisor_i; rem_o/quo_o the values after this step.
module hilo_muldiv_ctrl_div_radix2 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  assign shifted = {rem_i, quo_i[DATA_W-1]};
  assign diff    = shifted - {1'b0, divisor_i};

  // A set top bit of diff is a borrow: restore, and shift a 0 into the quotient.
  assign rem_o = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], ~diff[DATA_W]};
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU sequencer plus MTHI/MTLO writes.
// Latency: stall_o DATA_W+1 cycles, done_o/commit in cycle DATA_W+2 (FAST_MULT_EN: mul 2 / 3).
// Backpressure: stall_o holds EX from the accepting cycle until DONE; flush_i aborts.
// Ports: clk, resetn (sync, active-low), bus (hilo_muldiv_ctrl_if.slave).
// Optional macro FAST_MULT_EN: single-cycle multiplier in place of shift-add.
module hilo_muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 resetn,
  hilo_muldiv_ctrl_if.slave   bus
);
  import hilo_muldiv_ctrl_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);

  hilo_state_e         state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0]   opnd_q;     // mul: multiplicand; div: divisor
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                is_div_q, neg_res_q, neg_rem_q, div0_q;

  logic                live, start_mul, start_div, sgn, sign_a, sign_b;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [2*DATA_W-1:0] mul_d, div_d, prod;
  logic [DATA_W-1:0]   rem_d, quo_d, quo_fix, rem_fix, hi_res, lo_res;

  // Flush beats any new request in IDLE, including MTHI/MTLO.
  assign live      = bus.valid_i & ~bus.flush_i & (state_q == ST_IDLE);
  assign start_mul = live & ((bus.op_i == HILO_MULT) | (bus.op_i == HILO_MULTU));
  assign start_div = live & ((bus.op_i == HILO_DIV)  | (bus.op_i == HILO_DIVU));

  assign sgn    = is_signed_op(bus.op_i);
  assign sign_a = sgn & bus.src_a_i[DATA_W-1];
  assign sign_b = sgn & bus.src_b_i[DATA_W-1];
  assign abs_a  = sign_a ? -bus.src_a_i : bus.src_a_i;
  assign abs_b  = sign_b ? -bus.src_b_i : bus.src_b_i;

`ifdef FAST_MULT_EN
  assign mul_d = {{DATA_W{1'b0}}, opnd_q} * {{DATA_W{1'b0}}, acc_q[DATA_W-1:0]};
`else
  // Add the multiplicand into the upper half when the multiplier LSB is set, then shift right.
  logic [DATA_W:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
  assign mul_d   = {mul_sum, acc_q[DATA_W-1:1]};
`endif

  hilo_muldiv_ctrl_div_radix2 #(.DATA_W(DATA_W)) u_div_step (
    .rem_i     (acc_q[2*DATA_W-1:DATA_W]),
    .quo_i     (acc_q[DATA_W-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );
  assign div_d = {rem_d, quo_d};

  // Sign fix-up; a zero divisor leaves HI = dividend (magnitude re-signed) and forces LO to all ones.
  assign prod    = neg_res_q ? -acc_q : acc_q;
  assign quo_fix = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  assign hi_res  = is_div_q ? rem_fix : prod[2*DATA_W-1:DATA_W];
  assign lo_res  = is_div_q ? (div0_q ? {DATA_W{1'b1}} : quo_fix) : prod[DATA_W-1:0];

  assign bus.stall_o = start_mul | start_div | (state_q == ST_MUL) | (state_q == ST_DIV);
  assign bus.done_o  = (state_q == ST_DONE) & ~bus.flush_i;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (bus.flush_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start_mul | start_div) begin
            state_q   <= start_div ? ST_DIV : ST_MUL;
            acc_q     <= {{DATA_W{1'b0}}, start_div ? abs_a : abs_b};
            opnd_q    <= start_div ? abs_b : abs_a;
            is_div_q  <= start_div;
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            div0_q    <= start_div & (bus.src_b_i == '0);
          end else if (live & (bus.op_i == HILO_MTHI)) begin
            hi_q <= bus.src_a_i;
          end else if (live & (bus.op_i == HILO_MTLO)) begin
            lo_q <= bus.src_a_i;
          end
        end
        ST_MUL: begin
          acc_q <= mul_d;
`ifdef FAST_MULT_EN
          state_q <= ST_DONE;
`else
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= ST_DONE;
`endif
        end
        ST_DIV: begin
          acc_q <= div_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          hi_q    <= hi_res;
          lo_q    <= lo_res;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
